datapath_core: RTL and testbench
================================

DATAPATH_CORE -- requirements
Module: datapath_core

Interface
REQ-001 clock  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; sampled only on rising clock edge.
REQ-003 read_reg_num1  input  2  register-file address of ALU operand A.
REQ-004 read_reg_num2  input  2  register-file address of ALU operand B.
REQ-005 write_reg  input  2  register-file address written with the ALU result.
REQ-006 alu_control  input  3  ALU operation select.
REQ-007 regwrite  input  1  write enable; 1 = write ALU result on rising edge.
REQ-008 zero_flag  output  1  1 when the current 32-bit ALU result equals zero.
REQ-009 DATA_WIDTH parameter, default 32, register and ALU width; all other widths fixed as listed.

Function
REQ-010 Register file SHALL hold 4 registers R0..R3 of DATA_WIDTH bits, all writable (no hardwired-zero register).
REQ-011 Reads SHALL be combinational: A = R[read_reg_num1], B = R[read_reg_num2]; both ports may address the same register.
REQ-012 ALU SHALL be purely combinational on A, B, alu_control.
REQ-013 alu_control 000 = A AND B; 001 = A OR B; 010 = A + B; 011 = A XOR B; 100 = NOR(A,B); 110 = A - B; 111 = SLT (1 if signed A < signed B, else 0, zero-extended).
REQ-014 alu_control 101 (unused) SHALL produce result 0.
REQ-015 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; no carry or overflow output.
REQ-016 zero_flag SHALL be combinational: 1 iff ALU result == 0; it follows operand/opcode changes in the same cycle with no register delay.
REQ-017 On rising edge with reset=1 and regwrite=1, R[write_reg] SHALL load the ALU result computed from pre-edge register values.
REQ-018 regwrite=0: register file SHALL hold all values.
REQ-019 Write to a register also being read SHALL not bypass: read returns the old value until after the edge, new value afterward (1-cycle write latency).
REQ-020 Only one register SHALL be written per cycle; other registers unchanged.
REQ-021 Writing a result back into a source register (e.g. write_reg = read_reg_num1) SHALL be legal; the new value feeds the ALU in the next cycle.

Reset
REQ-022 On rising edge with reset=0, R0..R3 SHALL load 0x0, 0x1, 0x2, 0x3 respectively.
REQ-023 Reset SHALL take priority over regwrite; no write occurs in a reset cycle.
REQ-024 Reset asserted mid-operation SHALL reinitialize all registers at that edge regardless of other inputs.
REQ-025 Reset SHALL not directly force zero_flag; after reset zero_flag reflects the ALU result on reset register values.
REQ-026 Between power-up and the first reset edge, register contents are undefined; the bench SHALL apply reset before checking.

Verification
REQ-027 Reset low for 1 edge, then high; read 0,0, ADD, regwrite=0 -> result 0, zero_flag=1; R0..R3 = 0,1,2,3.
REQ-028 Read 0,1, ADD, regwrite=1, write_reg=2 -> zero_flag=0 before edge; after edge R2=1 (read 2,2 SUB gives zero_flag=1).
REQ-029 Read 0,1, SUB, write_reg=3, regwrite=1 -> R3=0xFFFFFFFF; then read 3,1 ADD -> wraps to 0, zero_flag=1.
REQ-030 Read 3,0 SLT with R3=0xFFFFFFFF, R0=0 -> result 1, zero_flag=0; read 0,3 SLT -> result 0, zero_flag=1.
REQ-031 regwrite=1 and reset=0 on the same edge with write_reg=1 and ADD of R2+R3 -> after edge R1=1 (reset value), no write.
REQ-032 Read 1,2 AND with R1=1, R2=2 -> zero_flag=1; OR -> result 3, zero_flag=0; opcode 101 -> zero_flag=1.

Source files
------------

// File: rtl/datapath_core_if.sv
// Control/observation bundle for datapath_core: register addresses, ALU opcode,
// write enable, and the combinational zero flag plus an ALU result debug tap.
interface datapath_core_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            read_reg_num1;
  logic [1:0]            read_reg_num2;
  logic [1:0]            write_reg;
  logic [2:0]            alu_control;
  logic                  regwrite;
  logic                  zero_flag;
  logic [DATA_WIDTH-1:0] dbg_alu_result;

  modport master (
    output read_reg_num1,
    output read_reg_num2,
    output write_reg,
    output alu_control,
    output regwrite,
    input  zero_flag,
    input  dbg_alu_result
  );

  modport slave (
    input  read_reg_num1,
    input  read_reg_num2,
    input  write_reg,
    input  alu_control,
    input  regwrite,
    output zero_flag,
    output dbg_alu_result
  );
endinterface

// File: rtl/datapath_core.sv
// Four-entry register file feeding a combinational ALU whose result is written
// back on the rising edge when regwrite is set; no read bypass.
module datapath_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset,
  datapath_core_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_NOR = 3'b100,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  logic [DATA_WIDTH-1:0] regs_q [4];
  logic [DATA_WIDTH-1:0] regs_d [4];
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] alu_result;

  always_comb begin
    op_a = regs_q[bus.read_reg_num1];
    op_b = regs_q[bus.read_reg_num2];
  end

  // Opcode 101 is unassigned and deliberately yields zero.
  always_comb begin
    alu_result = '0;
    case (bus.alu_control)
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_ADD:  alu_result = op_a + op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_NOR:  alu_result = ~(op_a | op_b);
      OP_SUB:  alu_result = op_a - op_b;
      OP_SLT:  alu_result[0] = ($signed(op_a) < $signed(op_b));
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.regwrite) begin
      regs_d[bus.write_reg] = alu_result;
    end
  end

  // Reset loads each register with its own index and overrides any write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= DATA_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign bus.zero_flag      = (alu_result == '0);
  assign bus.dbg_alu_result = alu_result;

endmodule

// File: tb/tb_datapath_core.sv
// Directed bench for datapath_core: reset values, every ALU op, write-back
// timing, reset-over-write priority and the zero flag.
module tb_datapath_core;

  localparam logic [2:0] AND_OP = 3'b000;
  localparam logic [2:0] OR_OP  = 3'b001;
  localparam logic [2:0] ADD_OP = 3'b010;
  localparam logic [2:0] XOR_OP = 3'b011;
  localparam logic [2:0] NOR_OP = 3'b100;
  localparam logic [2:0] UNUSED = 3'b101;
  localparam logic [2:0] SUB_OP = 3'b110;
  localparam logic [2:0] SLT_OP = 3'b111;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  datapath_core_if #(.DATA_WIDTH(32)) bus ();

  datapath_core #(.DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("check %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // driver tasks
  task automatic apply(input logic [1:0] r1, input logic [1:0] r2, input logic [2:0] op,
                       input logic [1:0] wr, input logic rw);
    bus.read_reg_num1 = r1;
    bus.read_reg_num2 = r2;
    bus.alu_control   = op;
    bus.write_reg     = wr;
    bus.regwrite      = rw;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic peek(input string tag, input logic [1:0] n, input logic [31:0] expected);
    apply(n, n, OR_OP, 2'd0, 1'b0);
    check(tag, bus.dbg_alu_result, expected);
  endtask

  task automatic expect_alu(input string tag, input logic [31:0] res, input logic zf);
    check({tag, "_res"}, bus.dbg_alu_result, res);
    check({tag, "_zf"}, {31'd0, bus.zero_flag}, {31'd0, zf});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.read_reg_num1 = 2'd0;
    bus.read_reg_num2 = 2'd0;
    bus.write_reg     = 2'd0;
    bus.alu_control   = ADD_OP;
    bus.regwrite      = 1'b0;

    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // reset state
    apply(2'd0, 2'd0, ADD_OP, 2'd0, 1'b0);
    expect_alu("rst_add00", 32'h0, 1'b1);
    peek("rst_r0", 2'd0, 32'h0);
    peek("rst_r1", 2'd1, 32'h1);
    peek("rst_r2", 2'd2, 32'h2);
    peek("rst_r3", 2'd3, 32'h3);

    // R2 <= R0 + R1
    apply(2'd0, 2'd1, ADD_OP, 2'd2, 1'b1);
    expect_alu("add01_pre", 32'h1, 1'b0);
    step();
    apply(2'd2, 2'd2, SUB_OP, 2'd0, 1'b0);
    expect_alu("sub22", 32'h0, 1'b1);
    peek("r2_after_add", 2'd2, 32'h1);

    // write back into the source register: R2 <= R2 + R2
    apply(2'd2, 2'd2, ADD_OP, 2'd2, 1'b1);
    check("wb_pre", bus.dbg_alu_result, 32'h2);
    step();
    check("wb_post", bus.dbg_alu_result, 32'h4);
    bus.regwrite = 1'b0;
    #1;
    peek("wb_r2", 2'd2, 32'h2);

    // R3 <= R0 - R1 wraps
    apply(2'd0, 2'd1, SUB_OP, 2'd3, 1'b1);
    expect_alu("sub01", 32'hFFFF_FFFF, 1'b0);
    step();
    apply(2'd3, 2'd1, ADD_OP, 2'd0, 1'b0);
    expect_alu("add31_wrap", 32'h0, 1'b1);
    peek("r3_neg1", 2'd3, 32'hFFFF_FFFF);
    peek("r0_untouched", 2'd0, 32'h0);
    peek("r1_untouched", 2'd1, 32'h1);

    // signed compare
    apply(2'd3, 2'd0, SLT_OP, 2'd0, 1'b0);
    expect_alu("slt30", 32'h1, 1'b0);
    apply(2'd0, 2'd3, SLT_OP, 2'd0, 1'b0);
    expect_alu("slt03", 32'h0, 1'b1);

    // XOR / NOR
    apply(2'd3, 2'd1, XOR_OP, 2'd0, 1'b0);
    expect_alu("xor31", 32'hFFFF_FFFE, 1'b0);
    apply(2'd0, 2'd1, NOR_OP, 2'd0, 1'b0);
    expect_alu("nor01", 32'hFFFF_FFFE, 1'b0);
    apply(2'd3, 2'd0, NOR_OP, 2'd0, 1'b0);
    expect_alu("nor30", 32'h0, 1'b1);

    // regwrite low holds everything
    apply(2'd0, 2'd1, ADD_OP, 2'd3, 1'b0);
    step();
    peek("hold_r3", 2'd3, 32'hFFFF_FFFF);

    // reset beats a simultaneous write
    apply(2'd2, 2'd3, ADD_OP, 2'd1, 1'b1);
    check("pre_rst_sum", bus.dbg_alu_result, 32'h1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.regwrite = 1'b0;
    #1;
    peek("rst2_r0", 2'd0, 32'h0);
    peek("rst2_r1", 2'd1, 32'h1);
    peek("rst2_r2", 2'd2, 32'h2);
    peek("rst2_r3", 2'd3, 32'h3);

    // logic ops on reset values
    apply(2'd1, 2'd2, AND_OP, 2'd0, 1'b0);
    expect_alu("and12", 32'h0, 1'b1);
    apply(2'd1, 2'd2, OR_OP, 2'd0, 1'b0);
    expect_alu("or12", 32'h3, 1'b0);
    apply(2'd1, 2'd2, UNUSED, 2'd0, 1'b0);
    expect_alu("op101", 32'h0, 1'b1);
    apply(2'd1, 2'd2, SLT_OP, 2'd0, 1'b0);
    expect_alu("slt12", 32'h1, 1'b0);
    apply(2'd2, 2'd1, SLT_OP, 2'd0, 1'b0);
    expect_alu("slt21", 32'h0, 1'b1);
    apply(2'd3, 2'd1, SUB_OP, 2'd0, 1'b0);
    expect_alu("sub31", 32'h2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
